mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  Load/store unit of the RV32I core. Takes one memory request per instruction from the execute stage and performs it as a single-beat AXI4 transaction on the core's data master (M_DATA_AXI_*).
//  Returns aligned, sign/zero-extended load data and destination register to writeback, and raises MEM_WAIT for the core's global stall.
// PARAMETERS
//  C_M_AXI_THREAD_ID_WIDTH 1  AXI ID width
//  C_M_AXI_ADDR_WIDTH      32 address width
//  C_M_AXI_DATA_WIDTH      32 data width; only 32 is supported
//  C_M_AXI_AWUSER_WIDTH    1  AWUSER width
//  C_M_AXI_ARUSER_WIDTH    1  ARUSER width
//  C_M_AXI_WUSER_WIDTH     4  WUSER width
// PORTS
//  CLK          in  1  clock; single clock domain
//  RST          in  1  synchronous, active-high reset
//  REQ_VALID    in  1  execute stage presents a memory request
//  REQ_STORE    in  1  1 = store, 0 = load
//  REQ_FUNCT3   in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  REQ_ADDR     in  32 effective byte address
//  REQ_WDATA    in  32 rs2 value for stores
//  REQ_RD       in  5  load destination register
//  MEM_WAIT     out 1  stall request to the core, combinational
//  RES_VALID    out 1  1-cycle pulse: request completed
//  RES_DATA     out 32 extended load data; 0 for stores
//  RES_RD       out 5  destination register; 0 for stores
//  RES_ERR      out 1  SLVERR/DECERR or misaligned access, qualified by RES_VALID
//  M_AXI_AW*/W*/B*/AR*/R*  AXI4 master; full channel set as on the core's data port
// BEHAVIOUR
//  Constant outputs: *LEN=0, *SIZE=3'b010, *BURST=01, *LOCK=0, *CACHE=0011, *PROT=0, *QOS=0, *ID/*USER=0, WLAST=WVALID.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
//   IDLE: request accepted when REQ_VALID=1 and RES_VALID=0. Request is latched. Next state is RD_ADDR for a load, WR_REQ for a store.
//   RD_ADDR: ARVALID=1, held until ARREADY=1, then RD_DATA.
//   RD_DATA: RREADY=1. On RVALID, RDATA/RRESP are latched, then DONE.
//   WR_REQ: AWVALID and WVALID both assert on entry. Each deasserts independently on its own READY. Both accepted -> WR_RESP.
//   WR_RESP: BREADY=1. On BVALID, BRESP is latched, then DONE.
//   DONE: RES_VALID=1 for exactly one cycle, then IDLE.
//  MEM_WAIT = REQ_VALID & ~RES_VALID. The core advances in the DONE cycle. The re-accept guard stops a stale request from being taken twice.
//  Addresses: ARADDR/AWADDR = {addr[31:2],2'b00}; a = addr[1:0].
//  Stores:
//   SB: WSTRB=4'b0001<<a, WDATA={4{wdata[7:0]}}.
//   SH: WSTRB=4'b0011<<a, WDATA={2{wdata[15:0]}}.
//   SW: WSTRB=4'b1111.
//  Loads: shifted = RDATA>>(8*a). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
//  RRESP/BRESP != 2'b00 -> RES_ERR=1, RES_DATA=0.
//  Minimum latency with READY/VALID always high: load 4 cycles accept->RES_VALID; store 4 cycles.
//  Reset: state=IDLE. All VALID/READY outputs, RES_VALID, RES_ERR, RES_DATA and RES_RD are 0. Reset mid-transaction abandons the transaction; the interconnect is reset together with the core.
//  Illegal funct3 (011, 110, 111): treated as LW/SW.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   Misaligned access (H with a[0]=1, W with a!=0) issues no bus transaction.
//   IDLE goes directly to DONE; RES_ERR=1, RES_DATA=REQ_ADDR.
//  Undefined: low address bits are cleared to natural alignment (H: a[0]=0, W: a=0) and the access proceeds. RES_ERR is set only on bus errors.
// STRUCTURE
//  core_defs.vh: funct3 codes, AXI RESP codes, FSM state encodings. Shared with the decode and execute stages.
//  Sub-module mem_align: combinational store lane/strobe generation and load shift/extension.
// TESTING
//  LW addr 0x100, RDATA 0xDEADBEEF, zero-wait slave -> RES_VALID at cycle 4, RES_DATA 0xDEADBEEF, RES_RD as given.
//  LB addr 0x103, RDATA 0x80123456 -> RES_DATA 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008012.
//  SB addr 0x201, wdata 0x000000AB -> AWADDR 0x200, WSTRB 0010, WDATA 0xABABABAB. SH addr 0x202 -> WSTRB 1100.
//  AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle; AWVALID held; one B handshake; MEM_WAIT high throughout.
//  RRESP=2'b10 on load -> RES_ERR=1, RES_DATA=0. Random ARREADY/RVALID back-pressure: no duplicate transactions.
//  LW addr 0x102: with MEM_MISALIGN_TRAP_EN -> no ARVALID, RES_ERR=1, RES_DATA=0x102; without -> ARADDR 0x100.
//  RST asserted in RD_DATA -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the RV32I load/store unit: funct3 width decoding,
// AXI response codes, FSM state encodings and small alignment helpers.
// Imported by mem_access and mem_access_align.
// ----------------------------------------------------------------------------
package mem_access_pkg;

    // funct3 codes that select a sub-word access; every other code is a word.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Any response other than OKAY is reported as an error.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    // Illegal funct3 codes (011, 110, 111) fall into the word case.
    function automatic acc_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    // Byte offset forced to the natural alignment of the access size.
    function automatic logic [1:0] align_offset(input acc_size_t sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return align_offset(f3_size(f3), a) != a;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// ----------------------------------------------------------------------------
// mem_access_align
// Combinational data steering for the load/store unit.
//   i_funct3  : RV32I funct3 of the access
//   i_offset  : byte address bits [1:0] (cleared to natural alignment here)
//   i_wdata   : rs2 value for stores
//   i_rdata   : raw 32-bit word returned by the bus for loads
//   o_wstrb   : byte strobes for the store
//   o_wdata   : store data replicated across all candidate lanes
//   o_rdata   : load data shifted down and sign/zero-extended
// ----------------------------------------------------------------------------
module mem_access_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    acc_size_t   w_size;
    logic [1:0]  w_a;
    logic        w_signed;
    logic [31:0] w_shifted;

    assign w_size    = f3_size(i_funct3);
    assign w_a       = align_offset(w_size, i_offset);
    assign w_signed  = ~i_funct3[2];
    assign w_shifted = i_rdata >> {w_a, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
        case (w_size)
            SZ_BYTE: begin
                o_wstrb = 4'b0001 << w_a;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_wstrb = 4'b0011 << w_a;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
// Load/store unit of the RV32I core. Each request from execute becomes one
// single-beat AXI4 transaction; the extended result goes back to writeback.
//   CLK, RST         : clock, synchronous active-high reset
//   REQ_*            : request from execute (valid, store, funct3, addr, wdata, rd)
//   MEM_WAIT         : combinational stall to the core
//   RES_*            : one-cycle result pulse (valid, data, rd, err)
//   M_AXI_AW/W/B/AR/R: AXI4 master data port
// Build option: define MEM_MISALIGN_TRAP_EN to report misaligned accesses as
// errors without a bus transaction; otherwise low address bits are cleared.
// ----------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int C_M_AXI_WUSER_WIDTH     = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               REQ_VALID,
    input  logic                               REQ_STORE,
    input  logic [2:0]                         REQ_FUNCT3,
    input  logic [31:0]                        REQ_ADDR,
    input  logic [31:0]                        REQ_WDATA,
    input  logic [4:0]                         REQ_RD,
    output logic                               MEM_WAIT,
    output logic                               RES_VALID,
    output logic [31:0]                        RES_DATA,
    output logic [4:0]                         RES_RD,
    output logic                               RES_ERR,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [7:0]                         M_AXI_AWLEN,
    output logic [2:0]                         M_AXI_AWSIZE,
    output logic [1:0]                         M_AXI_AWBURST,
    output logic                               M_AXI_AWLOCK,
    output logic [3:0]                         M_AXI_AWCACHE,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic [3:0]                         M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
    output logic                               M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    logic [2:0]  r_state;
    logic        r_aw_pend;
    logic        r_w_pend;
    logic        r_res_valid;
    logic        r_res_err;
    logic [31:0] r_res_data;
    logic [4:0]  r_res_rd;

    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;

    logic        w_accept;
    logic        w_aw_done;
    logic        w_w_done;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_ext;
    logic        w_unused;

    // The guard keeps the request still presented during DONE from being
    // taken a second time.
    assign w_accept = REQ_VALID & ~r_res_valid;
    // A write channel is finished once accepted earlier or accepted this cycle.
    assign w_aw_done = ~r_aw_pend | M_AXI_AWREADY;
    assign w_w_done  = ~r_w_pend  | M_AXI_WREADY;

    mem_access_align u_align (
        .i_funct3 (r_funct3),
        .i_offset (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (M_AXI_RDATA),
        .o_wstrb  (w_wstrb),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata_ext)
    );

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
        if (RST) begin
            r_state     <= ST_IDLE;
            r_aw_pend   <= 1'b0;
            r_w_pend    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
        end else begin
            // Result registers pulse only on the transition into DONE.
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (is_misaligned(REQ_FUNCT3, REQ_ADDR[1:0])) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_data  <= REQ_ADDR;
                            r_res_rd    <= REQ_STORE ? 5'd0 : REQ_RD;
                        end else
`endif
                        if (REQ_STORE) begin
                            r_state   <= ST_WR_REQ;
                            r_aw_pend <= 1'b1;
                            r_w_pend  <= 1'b1;
                        end else begin
                            r_state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) r_state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_rd    <= r_rd;
                        if (M_AXI_RRESP != RESP_OKAY) r_res_err  <= 1'b1;
                        else                          r_res_data <= w_rdata_ext;
                    end
                end
                ST_WR_REQ: begin
                    if (M_AXI_AWREADY) r_aw_pend <= 1'b0;
                    if (M_AXI_WREADY)  r_w_pend  <= 1'b0;
                    if (w_aw_done && w_w_done) r_state <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_err   <= (M_AXI_BRESP != RESP_OKAY);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: request holding registers carry no reset; they are always loaded before being read.
    always_ff @(posedge CLK) begin
        if (r_state == ST_IDLE && w_accept) begin
            r_funct3 <= REQ_FUNCT3;
            r_addr   <= REQ_ADDR;
            r_wdata  <= REQ_WDATA;
            r_rd     <= REQ_RD;
        end
    end

    assign MEM_WAIT  = w_accept;
    assign RES_VALID = r_res_valid;
    assign RES_DATA  = r_res_data;
    assign RES_RD    = r_res_rd;
    assign RES_ERR   = r_res_err;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = {r_addr[31:2], 2'b00};
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_AWVALID = r_aw_pend;

    assign M_AXI_WDATA   = w_wdata;
    assign M_AXI_WSTRB   = w_wstrb;
    assign M_AXI_WLAST   = r_w_pend;
    assign M_AXI_WUSER   = '0;
    assign M_AXI_WVALID  = r_w_pend;

    assign M_AXI_BREADY  = (r_state == ST_WR_RESP);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = {r_addr[31:2], 2'b00};
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARUSER  = '0;
    assign M_AXI_ARVALID = (r_state == ST_RD_ADDR);

    assign M_AXI_RREADY  = (r_state == ST_RD_DATA);

    // Single outstanding transaction: IDs and RLAST carry no information.
    assign w_unused = &{1'b0, M_AXI_BID, M_AXI_RID, M_AXI_RLAST};

endmodule
